// File: rtl/aes_pkg.sv
// AES shared definitions: S-box table, xtime, round-constant seed, key-schedule
// FSM state type and 32-bit word type. Used by keyexpand and aes_sbox.
package aes_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} kx_state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: purely combinational byte substitution from aes_pkg::SBOX.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] val,
  output logic [7:0] sub
);

  // Table lookup.
  always_comb begin
    sub = SBOX[val];
  end

endmodule

// File: rtl/keyexpand.sv
// AES-128 key schedule. Loads the cipher key on start (round key 0) and
// produces round keys 1..NROUNDS one per next request.
// Byte i lives at bits [8i+7:8i]; word wj at bits [32j+31:32j].
// Build option: KEYEXPAND_PARALLEL_SBOX_EN uses four S-boxes (1-cycle SUB);
// otherwise one shared S-box walks the four bytes over 4 cycles.
module keyexpand
  import aes_pkg::*;
#(
  parameter int unsigned NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         next,
  output logic [127:0] roundkey,
  output logic [3:0]   round,
  output logic         busy,
  output logic         finish
);

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

  kx_state_t  state;
  logic       start_q;
  logic       next_q;
  logic       start_re;
  logic       next_re;
  logic [7:0] rcon;
  word_t      temp;
  word_t      w3;
  word_t      t;
  word_t      w0n, w1n, w2n, w3n;

`ifdef KEYEXPAND_PARALLEL_SBOX_EN
  word_t      sub_word;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.val(temp[8*g +: 8]), .sub(sub_word[8*g +: 8]));
  end
`else
  logic [1:0] cnt;
  logic [7:0] sbox_out;

  aes_sbox u_sbox (.val(temp[{cnt, 3'b000} +: 8]), .sub(sbox_out));
`endif

  // Rising-edge detection on the request inputs and next-round-key datapath.
  always_comb begin
    start_re = start & ~start_q;
    next_re  = next & ~next_q;
    w3       = roundkey[127:96];
    t        = temp ^ {24'h0, rcon};
    w0n      = roundkey[31:0] ^ t;
    w1n      = roundkey[63:32] ^ w0n;
    w2n      = roundkey[95:64] ^ w1n;
    w3n      = roundkey[127:96] ^ w2n;
  end

  // Key-schedule FSM; start always preempts whatever is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      next_q   <= 1'b0;
      roundkey <= '0;
      round    <= '0;
      busy     <= 1'b0;
      finish   <= 1'b0;
      rcon     <= RCON_INIT;
      temp     <= '0;
`ifndef KEYEXPAND_PARALLEL_SBOX_EN
      cnt      <= '0;
`endif
    end else begin
      start_q <= start;
      next_q  <= next;
      finish  <= 1'b0;
      if (start_re) begin
        roundkey <= key;
        round    <= '0;
        rcon     <= RCON_INIT;
        busy     <= 1'b0;
        state    <= DONE;
`ifndef KEYEXPAND_PARALLEL_SBOX_EN
        cnt      <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (next_re && (round < LAST_ROUND)) begin
              // temp holds RotWord(w3) and is substituted in place during SUB.
              temp  <= {w3[7:0], w3[31:8]};
              busy  <= 1'b1;
              state <= SUB;
`ifndef KEYEXPAND_PARALLEL_SBOX_EN
              cnt   <= '0;
`endif
            end
          end
          SUB: begin
`ifdef KEYEXPAND_PARALLEL_SBOX_EN
            temp  <= sub_word;
            state <= MIX;
`else
            temp[{cnt, 3'b000} +: 8] <= sbox_out;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= MIX;
`endif
          end
          MIX: begin
            roundkey <= {w3n, w2n, w1n, w0n};
            round    <= round + 4'd1;
            rcon     <= xtime(rcon);
            busy     <= 1'b0;
            state    <= DONE;
          end
          DONE: begin
            finish <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keyexpand.sv
// Self-checking bench for keyexpand: a byte-level FIPS-197 key-schedule model
// (S-box derived from GF(2^8) inversion) feeds a per-cycle finish checker;
// directed tests cover load, advance, saturation, abort and async reset.
module tb_keyexpand;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic         next = 1'b0;
  logic [127:0] roundkey;
  logic [3:0]   round;
  logic         busy;
  logic         finish;

  keyexpand #(.NROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .next(next),
    .roundkey(roundkey), .round(round), .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;

`ifdef KEYEXPAND_PARALLEL_SBOX_EN
  localparam int LAT_NEXT = 4;
`else
  localparam int LAT_NEXT = 7;
`endif
  localparam int LAT_START = 2;

  localparam logic [127:0] K1    = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] K1_R1 = 128'h05766c2a3939a323b12c548817fefaa0;
  localparam logic [127:0] K1_R10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
  localparam logic [127:0] K0_R1 = 128'h63636362636363626363636263636362;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int fin_count = 0;
  int fin_cyc = 0;
  int exp_round = 0;
  logic [7:0]   sb [256];
  logic [127:0] exp_keys [0:10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_round(input logic [127:0] k, input int n);
    logic [7:0] b [16];
    logic [7:0] tw [4];
    logic [7:0] rc;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = k[8*i +: 8];
    rc = 8'h01;
    for (int rr = 1; rr <= n; rr++) begin
      tw[0] = sb[b[13]] ^ rc;
      tw[1] = sb[b[14]];
      tw[2] = sb[b[15]];
      tw[3] = sb[b[12]];
      for (int j = 0; j < 4; j++) b[j] = b[j] ^ tw[j];
      for (int i = 4; i < 16; i++) b[i] = b[i] ^ b[i-4];
      rc = gmul(rc, 8'h02);
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  task automatic set_key(input logic [127:0] k);
    for (int r = 0; r <= 10; r++) exp_keys[r] = model_round(k, r);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Every finish pulse must present the model's key for the expected round.
  initial forever begin
    @(negedge clk);
    if (rst === 1'b0 && finish === 1'b1) begin
      fin_count++;
      fin_cyc = cyc;
      chk("fin_round", 128'(round), 128'(exp_round));
      chk("fin_key", roundkey, exp_keys[exp_round]);
      chk("fin_busy", 128'(busy), 128'd0);
    end
  end

  task automatic do_req(input bit is_start, input logic [127:0] k, input int hold,
                        input int lat, input string name);
    int c0, f0, n;
    @(negedge clk);
    c0 = cyc;
    f0 = fin_count;
    key = k;
    if (is_start) start = 1'b1; else next = 1'b1;
    n = 0;
    while (fin_count == f0 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == hold) begin start = 1'b0; next = 1'b0; end
    end
    if (n < hold) repeat (hold - n) @(negedge clk);
    start = 1'b0;
    next = 1'b0;
    chk({name, "_lat"}, 128'(fin_cyc - c0), 128'(lat));
    repeat (12) @(negedge clk);
    chk({name, "_single"}, 128'(fin_count - f0), 128'd1);
  endtask

  initial begin
    build_sbox();
    chk("model_sbox00", 128'(sb[0]), 128'h63);
    chk("model_sbox53", 128'(sb[8'h53]), 128'hed);
    chk("model_k1_r1", model_round(K1, 1), K1_R1);
    chk("model_k1_r10", model_round(K1, 10), K1_R10);
    chk("model_k0_r1", model_round('0, 1), K0_R1);

    #12;
    chk("rst_roundkey", roundkey, '0);
    chk("rst_round", 128'(round), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_finish", 128'(finish), 128'd0);
    #8 rst = 1'b0;

    // 1..3: load, advance through all rounds, then a saturated next.
    set_key(K1);
    exp_round = 0;
    do_req(1'b1, K1, 2, LAT_START, "t1_start");
    chk("t1_key", roundkey, K1);
    exp_round = 1;
    do_req(1'b0, K1, 2, LAT_NEXT, "t2_next");
    chk("t2_key", roundkey, K1_R1);
    for (int r = 2; r <= 10; r++) begin
      exp_round = r;
      do_req(1'b0, K1, 1, LAT_NEXT, "t3_next");
    end
    chk("t3_round", 128'(round), 128'd10);
    chk("t3_key", roundkey, K1_R10);
    begin
      int f0;
      @(negedge clk);
      f0 = fin_count;
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      repeat (12) @(negedge clk);
      chk("t3_sat_nofin", 128'(fin_count - f0), 128'd0);
      chk("t3_sat_key", roundkey, K1_R10);
      chk("t3_sat_round", 128'(round), 128'd10);
    end

    // 4: all-zero key.
    set_key('0);
    exp_round = 0;
    do_req(1'b1, '0, 1, LAT_START, "t4_start");
    exp_round = 1;
    do_req(1'b0, '0, 1, LAT_NEXT, "t4_next");
    chk("t4_key", roundkey, K0_R1);

    // 5: start mid-computation aborts; only the round-0 finish may appear.
    exp_round = 0;
    do_req(1'b1, '0, 1, LAT_START, "t5_load");
    begin
      int f0, c0, n;
      @(negedge clk);
      f0 = fin_count;
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      @(negedge clk);
      c0 = cyc;
      key = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (fin_count == f0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("t5_abort_lat", 128'(fin_cyc - c0), 128'(LAT_START));
      repeat (12) @(negedge clk);
      chk("t5_single", 128'(fin_count - f0), 128'd1);
      chk("t5_round", 128'(round), 128'd0);
      chk("t5_key", roundkey, '0);
    end

    // 6: asynchronous reset mid-computation, then rerun load and first round.
    set_key(K1);
    exp_round = 0;
    do_req(1'b1, K1, 1, LAT_START, "t6_load");
    exp_round = 1;
    do_req(1'b0, K1, 1, LAT_NEXT, "t6_r1");
    @(negedge clk);
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    @(negedge clk);
    chk("t6_busy_mid", 128'(busy), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_key", roundkey, '0);
    chk("t6_arst_round", 128'(round), 128'd0);
    chk("t6_arst_busy", 128'(busy), 128'd0);
    chk("t6_arst_finish", 128'(finish), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_round = 0;
    do_req(1'b1, K1, 2, LAT_START, "t6_restart");
    exp_round = 1;
    do_req(1'b0, K1, 2, LAT_NEXT, "t6_rerun");
    chk("t6_key", roundkey, K1_R1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
